// File: rtl/shifter_pipe_nb_pkg.sv
// Shared types and helpers for the pipelined logarithmic shifter.
package shifter_pipe_nb_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'd0,
        SHIFT_SRL  = 2'd1,
        SHIFT_SRA  = 2'd2,
        SHIFT_RSVD = 2'd3
    } shift_mode_e;

    // Widest operand bit_reverse can handle; callers cast in and out.
    localparam int SHIFT_MAX_W = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Reverses the low 'width' bits of value; upper bits of the result are 0.
    function automatic logic [SHIFT_MAX_W-1:0] bit_reverse(input logic [SHIFT_MAX_W-1:0] value,
                                                           input int width);
        logic [SHIFT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SHIFT_MAX_W; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_pipe_nb_if.sv
// Operand/result handshake bundle of the shifter. master = issuing core, slave = shifter.
interface shifter_pipe_nb_if
    import shifter_pipe_nb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    localparam int SHAMT_W = clog2(DATA_W);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [SHAMT_W-1:0] in_shamt_i;
    shift_mode_e       in_mode_i;
    logic [TAG_W-1:0]  in_tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [TAG_W-1:0]  out_tag_o;

    modport master (
        output in_valid_i, in_data_i, in_shamt_i, in_mode_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_tag_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_shamt_i, in_mode_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_tag_o
    );

endinterface

// File: rtl/shifter_pipe_nb_stage.sv
// One combinational log stage: right shift by DIST with a caller-supplied fill bit.
module shift_stage_nb #(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic              fill,
    input  logic              en,
    output logic [DATA_W-1:0] out
);

    assign out = en ? {{DIST{fill}}, data[DATA_W-1:DIST]} : data;

endmodule

// File: rtl/shifter_pipe_nb.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA) with valid/ready, flush and tag pass-through.
// Left shifts are done as bit-reverse -> right shift -> bit-reverse so every stage is a right shifter.
module shifter_pipe_nb
    import shifter_pipe_nb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    shifter_pipe_nb_if.slave bus
);

    localparam int L = clog2(DATA_W);
    localparam int P = (L + REG_EVERY - 1) / REG_EVERY;

    logic                         advance;
    logic [DATA_W-1:0]            ent_data;
    logic                         ent_fill;
    logic                         ent_sll;
    logic [L-1:0]                 ent_shamt;

    // Pipeline registers at group boundaries; the last one drives the outputs.
    logic [P-1:0]                 r_valid;
    logic [P-1:0]                 r_rev;
    logic [P-1:0][DATA_W-1:0]     r_data;
    logic [P-1:0][TAG_W-1:0]      r_tag;

    // Per-group inputs (entry for group 0, previous register otherwise) and group results.
    logic [P-1:0]                 src_valid;
    logic [P-1:0]                 src_rev;
    logic [P-1:0][DATA_W-1:0]     src_data;
    logic [P-1:0][TAG_W-1:0]      src_tag;
    logic [P-1:0][DATA_W-1:0]     grp_out;

    // Global stall: nothing moves while a result waits on the consumer.
    assign advance        = !r_valid[P-1] || bus.out_ready_i;
    assign bus.in_ready_o = advance && !flush_i;

    // Entry conditioning: reverse for SLL, sign fill for SRA, reserved mode forced to a no-op.
    assign ent_sll   = (bus.in_mode_i == SHIFT_SLL);
    assign ent_data  = ent_sll ? DATA_W'(bit_reverse(SHIFT_MAX_W'(bus.in_data_i), DATA_W))
                               : bus.in_data_i;
    assign ent_fill  = (bus.in_mode_i == SHIFT_SRA) && bus.in_data_i[DATA_W-1];
    assign ent_shamt = (bus.in_mode_i == SHIFT_RSVD) ? '0 : bus.in_shamt_i;

    for (genvar g = 0; g < P; g++) begin : g_grp
        localparam int FIRST = g * REG_EVERY;
        localparam int SW    = L - FIRST;
        localparam int NSTG  = (SW < REG_EVERY) ? SW : REG_EVERY;

        // sh holds only the shift-amount bits not yet consumed by earlier groups.
        logic [SW-1:0]              sh;
        logic                       fill;
        logic [NSTG:0][DATA_W-1:0]  chain;

        if (g == 0) begin : g_src
            assign sh           = ent_shamt;
            assign fill         = ent_fill;
            assign src_valid[g] = bus.in_valid_i;
            assign src_rev[g]   = ent_sll;
            assign src_data[g]  = ent_data;
            assign src_tag[g]   = bus.in_tag_i;
        end else begin : g_src
            assign sh           = g_grp[g-1].g_fwd.sh_q;
            assign fill         = g_grp[g-1].g_fwd.fill_q;
            assign src_valid[g] = r_valid[g-1];
            assign src_rev[g]   = r_rev[g-1];
            assign src_data[g]  = r_data[g-1];
            assign src_tag[g]   = r_tag[g-1];
        end

        assign chain[0] = src_data[g];

        for (genvar j = 0; j < NSTG; j++) begin : g_stg
            shift_stage_nb #(
                .DATA_W (DATA_W),
                .DIST   (1 << (FIRST + j))
            ) u_stage (
                .data (chain[j]),
                .fill (fill),
                .en   (sh[j]),
                .out  (chain[j+1])
            );
        end

        assign grp_out[g] = chain[NSTG];

        // Fill and remaining shift bits are only needed by later groups, so the last group keeps none.
        if (g < P - 1) begin : g_fwd
            logic [SW-REG_EVERY-1:0] sh_q;
            logic                    fill_q;

            // Carry the unconsumed shift bits and the fill bit alongside the data.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    sh_q   <= '0;
                    fill_q <= 1'b0;
                end else if (advance && !flush_i) begin
                    sh_q   <= sh[SW-1:REG_EVERY];
                    fill_q <= fill;
                end
            end
        end
    end

    // Boundary registers: flush kills every valid bit, otherwise all load together on advance.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid <= '0;
            r_rev   <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else if (advance) begin
            r_valid <= src_valid;
            r_rev   <= src_rev;
            r_data  <= grp_out;
            r_tag   <= src_tag;
        end
    end

    assign bus.out_valid_o = r_valid[P-1];
    assign bus.out_tag_o   = r_tag[P-1];
    assign bus.out_data_o  = r_rev[P-1] ? DATA_W'(bit_reverse(SHIFT_MAX_W'(r_data[P-1]), DATA_W))
                                        : r_data[P-1];

endmodule

// File: tb/tb_shifter_pipe_nb.sv
// Bench for shifter_pipe_nb: a 32b/REG_EVERY=2 instance for directed cases and a
// 64b/REG_EVERY=3 instance for a long random stream with a mid-stream reset.
module tb_shifter_pipe_nb;
    import shifter_pipe_nb_pkg::*;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic rst32_n, rst64_n, flush32, flush64;

    shifter_pipe_nb_if #(.DATA_W(32), .TAG_W(5)) bus32 ();
    shifter_pipe_nb_if #(.DATA_W(64), .TAG_W(5)) bus64 ();

    shifter_pipe_nb #(.DATA_W(32), .REG_EVERY(2), .TAG_W(5)) dut32 (
        .clk_i   (clk_sys),
        .rstn_i  (rst32_n),
        .flush_i (flush32),
        .bus     (bus32)
    );

    shifter_pipe_nb #(.DATA_W(64), .REG_EVERY(3), .TAG_W(5)) dut64 (
        .clk_i   (clk_sys),
        .rstn_i  (rst64_n),
        .flush_i (flush64),
        .bus     (bus64)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference: a P-deep delay line of finished results that moves only when the output is free.
    logic        mv [2][3];
    logic [63:0] md [2][3];
    logic [4:0]  mt [2][3];
    int          retired  [2];
    int          accepted [2];

    function automatic int lat(input int id);
        return (id == 0) ? 3 : 2;
    endfunction

    function automatic int wid(input int id);
        return (id == 0) ? 32 : 64;
    endfunction

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s,
                                              input logic [1:0] m, input int w);
        logic [63:0] mask, dm, sx;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        dm   = d & mask;
        case (m)
            2'd0: return (dm << s) & mask;
            2'd1: return dm >> s;
            2'd2: begin
                sx = dm[w-1] ? (dm | ~mask) : dm;
                return 64'($signed(sx) >>> s) & mask;
            end
            default: return dm;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic clear_model(input int id);
        for (int i = 0; i < 3; i++) begin
            mv[id][i] = 1'b0;
            md[id][i] = '0;
            mt[id][i] = '0;
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [63:0] d, input int s,
                         input logic [1:0] m, input logic [4:0] t, input logic rdy, input logic fl);
        if (id == 0) begin
            bus32.in_valid_i  = v;
            bus32.in_data_i   = d[31:0];
            bus32.in_shamt_i  = 5'(s);
            bus32.in_mode_i   = shift_mode_e'(m);
            bus32.in_tag_i    = t;
            bus32.out_ready_i = rdy;
            flush32           = fl;
        end else begin
            bus64.in_valid_i  = v;
            bus64.in_data_i   = d;
            bus64.in_shamt_i  = 6'(s);
            bus64.in_mode_i   = shift_mode_e'(m);
            bus64.in_tag_i    = t;
            bus64.out_ready_i = rdy;
            flush64           = fl;
        end
    endtask

    task automatic sample(input int id, output logic ir, output logic ov,
                          output logic [63:0] od, output logic [4:0] ot);
        if (id == 0) begin
            ir = bus32.in_ready_o;
            ov = bus32.out_valid_o;
            od = 64'(bus32.out_data_o);
            ot = bus32.out_tag_o;
        end else begin
            ir = bus64.in_ready_o;
            ov = bus64.out_valid_o;
            od = bus64.out_data_o;
            ot = bus64.out_tag_o;
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model, return at posedge+1.
    task automatic step(input int id, input logic v, input logic [63:0] d, input int s,
                        input logic [1:0] m, input logic [4:0] t, input logic rdy, input logic fl);
        int          p;
        logic        exp_ov, adv, ir, ov;
        logic [63:0] od;
        logic [4:0]  ot;
        string       nm;
        p  = lat(id);
        nm = $sformatf("dut%0d", wid(id));
        drive(id, v, d, s, m, t, rdy, fl);
        @(negedge clk_sys);
        sample(id, ir, ov, od, ot);
        exp_ov = mv[id][p-1];
        adv    = !exp_ov || rdy;
        check({nm, " in_ready"}, 64'(ir), 64'(adv && !fl));
        check({nm, " out_valid"}, 64'(ov), 64'(exp_ov));
        if (exp_ov) begin
            check({nm, " out_data"}, od, md[id][p-1]);
            check({nm, " out_tag"}, 64'(ot), 64'(mt[id][p-1]));
            if (rdy) retired[id]++;
        end
        if (fl) begin
            for (int i = 0; i < 3; i++) mv[id][i] = 1'b0;
        end else if (adv) begin
            for (int i = p - 1; i > 0; i--) begin
                mv[id][i] = mv[id][i-1];
                md[id][i] = md[id][i-1];
                mt[id][i] = mt[id][i-1];
            end
            mv[id][0] = v;
            md[id][0] = ref_shift(d, s, m, wid(id));
            mt[id][0] = t;
            if (v) accepted[id]++;
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int id, input int n);
        for (int i = 0; i < n; i++) step(id, 1'b0, '0, 0, 2'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic rand_step(input int id, input int flush_pct);
        logic v, rdy, fl;
        int   s;
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 99) < flush_pct);
        s   = $urandom_range(0, wid(id) - 1);
        step(id, v, {$urandom, $urandom}, s, 2'($urandom_range(0, 3)), 5'($urandom), rdy, fl);
    endtask

    // Issue one beat on the 32b instance and compare against a hand-derived constant P cycles later.
    task automatic directed32(input string name, input logic [31:0] d, input int s,
                              input logic [1:0] m, input logic [4:0] t, input logic [31:0] exp);
        step(0, 1'b1, 64'(d), s, m, t, 1'b1, 1'b0);
        idle(0, 2);
        check({name, " valid at P"}, 64'(bus32.out_valid_o), 64'd1);
        check({name, " result"}, 64'(bus32.out_data_o), 64'(exp));
        idle(0, 1);
    endtask

    initial begin
        int r0, a0;
        rst32_n = 1'b0;
        rst64_n = 1'b0;
        drive(0, 1'b0, '0, 0, 2'd0, 5'd0, 1'b1, 1'b0);
        drive(1, 1'b0, '0, 0, 2'd0, 5'd0, 1'b1, 1'b0);
        for (int id = 0; id < 2; id++) begin
            clear_model(id);
            retired[id]  = 0;
            accepted[id] = 0;
        end
        repeat (3) @(posedge clk_sys);
        #1;

        check("dut32 reset out_valid", 64'(bus32.out_valid_o), 64'd0);
        check("dut32 reset out_data", 64'(bus32.out_data_o), 64'd0);
        check("dut32 reset out_tag", 64'(bus32.out_tag_o), 64'd0);
        check("dut32 reset in_ready", 64'(bus32.in_ready_o), 64'd1);
        check("dut64 reset out_valid", 64'(bus64.out_valid_o), 64'd0);
        check("dut64 reset out_data", bus64.out_data_o, 64'd0);
        rst32_n = 1'b1;

        directed32("sra31", 32'h8000_0000, 31, 2'd2, 5'd1, 32'hFFFF_FFFF);
        directed32("srl31", 32'h8000_0000, 31, 2'd1, 5'd2, 32'h0000_0001);
        directed32("sll31", 32'h0000_0001, 31, 2'd0, 5'd3, 32'h8000_0000);
        directed32("sll0",  32'hDEAD_BEEF, 0,  2'd0, 5'd4, 32'hDEAD_BEEF);
        directed32("rsvd",  32'h1234_5678, 7,  2'd3, 5'd5, 32'h1234_5678);
        directed32("sra4p", 32'h7000_0000, 4,  2'd2, 5'd6, 32'h0700_0000);
        directed32("sll4",  32'h0F00_000F, 4,  2'd0, 5'd7, 32'hF000_00F0);

        // Back-to-back beats with tags 0..15 and a free consumer.
        r0 = retired[0];
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 64'($urandom), $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                 5'(i), 1'b1, 1'b0);
        end
        idle(0, 5);
        check("b2b retired", 64'(retired[0] - r0), 64'd16);

        // Consumer ready pattern 1,0,0,1 under a continuous stream.
        r0 = retired[0];
        a0 = accepted[0];
        for (int i = 0; i < 24; i++) begin
            step(0, 1'b1, 64'($urandom), $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                 5'($urandom), ((i % 4) == 0) || ((i % 4) == 3), 1'b0);
        end
        idle(0, 6);
        check("stall no loss", 64'(retired[0] - r0), 64'(accepted[0] - a0));

        // Two beats in flight, a third offered in the flush cycle.
        r0 = retired[0];
        step(0, 1'b1, 64'h1111_1111, 1, 2'd1, 5'd20, 1'b1, 1'b0);
        step(0, 1'b1, 64'h2222_2222, 2, 2'd1, 5'd21, 1'b1, 1'b0);
        step(0, 1'b1, 64'h3333_3333, 3, 2'd1, 5'd22, 1'b1, 1'b1);
        idle(0, 5);
        check("flush retired", 64'(retired[0] - r0), 64'd0);

        for (int i = 0; i < 1500; i++) rand_step(0, 2);
        idle(0, 5);

        // 64b instance: long random stream split by an asynchronous reset.
        rst64_n = 1'b1;
        for (int i = 0; i < 6000; i++) rand_step(1, 1);
        #2;
        rst64_n = 1'b0;
        #1;
        check("dut64 midrst out_valid", 64'(bus64.out_valid_o), 64'd0);
        check("dut64 midrst out_data", bus64.out_data_o, 64'd0);
        check("dut64 midrst out_tag", 64'(bus64.out_tag_o), 64'd0);
        clear_model(1);
        @(posedge clk_sys);
        #1;
        check("dut64 inrst out_valid", 64'(bus64.out_valid_o), 64'd0);
        rst64_n = 1'b1;
        for (int i = 0; i < 6000; i++) rand_step(1, 1);
        idle(1, 4);
        check("dut64 retired all", 64'(retired[1] > 3000), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
